brt_usb_utmi_tx: RTL
====================

Name: brt_usb_utmi_tx

Overview:
- Device-side USB packet transmitter on an 8-bit UTMI transmit interface.
- Accepts a send command (handshake, token or data packet) plus a byte-stream payload.
- Serialises PID, token fields or payload, then the CRC5/CRC16, honouring UTMI TxValid/TxReady.
- Sits between the device protocol engine and the PHY; it is the DUT counterpart the USB agent's host side receives from.

Parameters:
- MAX_PKT, 1024, maximum payload bytes per data packet (sets length counter width, clog2(MAX_PKT+1)).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- tx_start  in  1  command strobe, sampled only when tx_busy=0
- tx_kind  in  2  0=handshake, 1=token, 2=data, 3=reserved (ignored, no packet)
- tx_pid  in  4  PID[3:0]
- tx_addr  in  7  token address
- tx_endp  in  4  token endpoint
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_last  in  1  marks final payload byte
- s_zlp  in  1  sampled with tx_start; 1 = zero-length data packet, no payload consumed
- s_ready  out  1  payload byte accepted when s_valid&s_ready
- utmi_data  out  8  TX byte
- utmi_txvalid  out  1  UTMI TxValid
- utmi_txready  in  1  UTMI TxReady
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-cycle pulse after last byte accepted by PHY
- tx_err  out  1  sticky per packet, valid with tx_done: payload overflow (or abort)
- tx_len  out  clog2(MAX_PKT+1)  payload bytes sent, valid with tx_done

Behaviour:
- Reset (sync, rst_n=0 at clk edge): state IDLE.
  - utmi_txvalid, utmi_data, s_ready, tx_busy, tx_done, tx_err, tx_len all 0.
  - Reset mid-packet drops TxValid at the next edge; no CRC is emitted.
- States: IDLE, PID, TOK0, TOK1, DATA, CRC_LO, CRC_HI, DONE.
- All command fields are latched at tx_start.
- Output register rule: utmi_data/utmi_txvalid load a new byte only when utmi_txvalid=0 or utmi_txready=1. The byte is held stable while TxValid=1 and TxReady=0.
- Latency: tx_start at edge N → utmi_txvalid=1 with PID byte {~pid,pid} after edge N+1. tx_busy=1 from edge N+1 through DONE.
- Handshake packet: PID only, then DONE.
- Token packet:
  - TOK0 = {endp[0],addr[6:0]}.
  - TOK1 = {crc5[4:0],endp[3:1]}.
  - crc5 is computed over addr then endp, LSB-first, poly x^5+x^2+1, init 0x1F, complemented.
- Data packet:
  - DATA streams s_data; s_ready = (state==DATA) && (!utmi_txvalid || utmi_txready).
  - Each accepted byte updates CRC16: poly 0x8005 reflected, init 0xFFFF, LSB-first.
  - s_last (or s_zlp) moves to CRC_LO, then CRC_HI: complemented CRC, low byte first.
  - s_valid=0 in DATA leaves a gap with TxValid low; legal at this layer, and upstream guarantees no underrun.
- Overflow: if MAX_PKT bytes are accepted without s_last, set tx_err, stop accepting (s_ready=0), and go to CRC_LO with the CRC so far. Upstream must drain the remainder.
- DONE: entered once the final byte has TxReady handshake.
  - TxValid drops.
  - tx_done pulses for 1 cycle with tx_len/tx_err.
  - Returns to IDLE the next cycle; tx_busy=0 in IDLE.
- tx_start while busy: ignored. tx_start in DONE cycle: ignored. tx_kind=3: no state change.
- tx_len saturates at MAX_PKT.

Optional Feature:
- Macro BRT_USB_TX_ABORT_EN.
- Defined:
  - Adds input tx_abort (1 bit).
  - In any non-IDLE state, tx_abort=1 forces utmi_txvalid=0 at the next edge and goes to DONE. No CRC is emitted.
  - tx_done pulses with tx_err=1. s_ready=0 from the abort cycle.
- Not defined: port absent; packets always complete.

Test Plan:
- ACK (kind 0, pid 0x2), txready=1 → single byte 0xD2, then tx_done next cycle with tx_len=0, tx_err=0.
- SETUP token (kind 1, pid 0xD, addr 0, endp 0) → bytes 0x2D, 0x00, 0x10, then tx_done.
- DATA0 with 8-byte payload 80 06 00 01 00 00 40 00 → C3, 80 06 00 01 00 00 40 00, DD 94; tx_len=8.
- DATA1 with s_zlp=1 → 4B, 00, 00; tx_len=0; s_ready never asserted.
- TxReady stalls (low 3 cycles per byte, random) on a DATA0 4-byte packet → utmi_data stable during stalls, byte order/CRC identical to the unstalled run; reset asserted mid-payload → TxValid 0 next edge, no tx_done.
- MAX_PKT=4, 6 bytes offered → 4 bytes accepted, CRC over those 4, tx_err=1, tx_len=4. With BRT_USB_TX_ABORT_EN, abort during byte 2 → TxValid drops next edge, tx_done with tx_err=1.

Source files
------------

// File: rtl/brt_usb_utmi_tx.sv
// USB device-side packet transmitter on an 8-bit UTMI TX port (PID, token, data + CRC).
// Optional BRT_USB_TX_ABORT_EN adds a tx_abort input that cuts a packet short.
`timescale 1ns/1ps

module brt_usb_utmi_tx #(
  parameter int MAX_PKT = 1024,
  localparam int LW = $clog2(MAX_PKT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_start,
  input  logic [1:0]    tx_kind,
  input  logic [3:0]    tx_pid,
  input  logic [6:0]    tx_addr,
  input  logic [3:0]    tx_endp,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  input  logic          s_zlp,
  output logic          s_ready,
`ifdef BRT_USB_TX_ABORT_EN
  input  logic          tx_abort,
`endif
  output logic [7:0]    utmi_data,
  output logic          utmi_txvalid,
  input  logic          utmi_txready,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_err,
  output logic [LW-1:0] tx_len
);

  typedef enum logic [2:0] {
    IDLE, PID, TOK0, TOK1, DATA, CRC_LO, CRC_HI, DONE
  } state_t;

  localparam logic [LW-1:0] LAST = LW'(MAX_PKT - 1);

  state_t        state, state_n;
  logic [1:0]    kind_q;
  logic [3:0]    pid_q;
  logic [6:0]    addr_q;
  logic [3:0]    endp_q;
  logic          zlp_q;
  logic          fin, fin_n;
  logic [15:0]   crc, crc_n;
  logic [LW-1:0] cnt, cnt_n;
  logic          err, err_n;
  logic          txv_n;
  logic [7:0]    data_n;
  logic          start;
  logic          load;
  logic [4:0]    crc5;

  function automatic logic [4:0] crc5_f(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_f(
    input logic [15:0] c_in,
    input logic [7:0]  d
  );
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'ha001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign start = (state == IDLE) && tx_start
              && (tx_kind != 2'd3);
  assign load  = !utmi_txvalid || utmi_txready;
  assign crc5  = crc5_f({endp_q, addr_q});

  assign tx_busy = (state != IDLE);
  assign tx_done = (state == DONE);
  assign tx_err  = err;
  assign tx_len  = cnt;

  always_comb begin
    state_n = state;
    txv_n   = utmi_txvalid;
    data_n  = utmi_data;
    crc_n   = crc;
    cnt_n   = cnt;
    err_n   = err;
    fin_n   = fin;
    s_ready = 1'b0;
    // fin: the final byte sits in the output register awaiting TxReady
    if (fin) begin
      if (utmi_txready) begin
        state_n = DONE;
        txv_n   = 1'b0;
        fin_n   = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = PID;
            crc_n   = 16'hffff;
            cnt_n   = '0;
            err_n   = 1'b0;
            fin_n   = 1'b0;
          end
        end
        PID: begin
          if (load) begin
            data_n = {~pid_q, pid_q};
            txv_n  = 1'b1;
            unique case (1'b1)
              (kind_q == 2'd0): fin_n   = 1'b1;
              (kind_q == 2'd1): state_n = TOK0;
              default:          state_n = zlp_q ? CRC_LO : DATA;
            endcase
          end
        end
        TOK0: begin
          if (load) begin
            data_n  = {endp_q[0], addr_q};
            txv_n   = 1'b1;
            state_n = TOK1;
          end
        end
        TOK1: begin
          if (load) begin
            data_n = {crc5, endp_q[3:1]};
            txv_n  = 1'b1;
            fin_n  = 1'b1;
          end
        end
        DATA: begin
          s_ready = load;
          if (load) begin
            if (s_valid) begin
              data_n = s_data;
              txv_n  = 1'b1;
              crc_n  = crc16_f(crc, s_data);
              cnt_n  = cnt + LW'(1);
              if (s_last) begin
                state_n = CRC_LO;
              end else if (cnt == LAST) begin
                err_n   = 1'b1;
                state_n = CRC_LO;
              end
            end else begin
              txv_n = 1'b0;
            end
          end
        end
        CRC_LO: begin
          if (load) begin
            data_n  = ~crc[7:0];
            txv_n   = 1'b1;
            state_n = CRC_HI;
          end
        end
        CRC_HI: begin
          if (load) begin
            data_n = ~crc[15:8];
            txv_n  = 1'b1;
            fin_n  = 1'b1;
          end
        end
        DONE: begin
          state_n = IDLE;
          txv_n   = 1'b0;
        end
      endcase
    end
`ifdef BRT_USB_TX_ABORT_EN
    if (tx_abort && state != IDLE && state != DONE) begin
      state_n = DONE;
      txv_n   = 1'b0;
      fin_n   = 1'b0;
      err_n   = 1'b1;
      s_ready = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      utmi_txvalid <= 1'b0;
      utmi_data    <= '0;
      crc          <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      fin          <= 1'b0;
      kind_q       <= '0;
      pid_q        <= '0;
      addr_q       <= '0;
      endp_q       <= '0;
      zlp_q        <= 1'b0;
    end else begin
      state        <= state_n;
      utmi_txvalid <= txv_n;
      utmi_data    <= data_n;
      crc          <= crc_n;
      cnt          <= cnt_n;
      err          <= err_n;
      fin          <= fin_n;
      if (start) begin
        kind_q <= tx_kind;
        pid_q  <= tx_pid;
        addr_q <= tx_addr;
        endp_q <= tx_endp;
        zlp_q  <= s_zlp;
      end
    end
  end

endmodule
